// File: rtl/axi_dpd_reader_pkg.sv
// Shared types and helpers for the DPD capture-buffer AXI reader.
// Holds the FSM state encoding, AXI response/prot constants and word addressing.
package axi_dpd_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_OUT,
        ST_DONE
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // Byte address of a 32-bit buffer word; the caller truncates to its bus width.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/axi_dpd_capture_reader.sv
// Drains the DPD capture buffer over AXI4-Lite reads and re-emits the words as AXI-Stream.
// Optional build macro AXI_DPD_CAPTURE_READER_RRESP_CHECK_EN: error responses abort the transfer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a rising edge on start
// AR      | read address valid for word idx, held until arready
// R       | rready high, waiting for read data
// OUT     | stream beat valid, held until tready
// DONE    | one-cycle done pulse, then back to IDLE
module axi_dpd_capture_reader
    import axi_dpd_reader_pkg::*;
#(
    parameter int unsigned           CAP_DEPTH  = 12,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0000
) (
    input  logic                  s_axi_aclk,
    input  logic                  data_rstn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_err,
    output logic                  m_axi_arvalid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    output logic                  m_axi_rready,
    output logic                  m_axis_tvalid,
    output logic [31:0]           m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    state_t               state_q, state_d;
    logic                 start_q;
    logic [CAP_DEPTH-1:0] idx_q, idx_d;
    logic [31:0]          tdata_q, tdata_d;
    logic                 tlast_q, tlast_d;
    logic                 start_rise;

    assign start_rise = start & ~start_q;

    always_ff @(posedge s_axi_aclk or negedge data_rstn) begin
        if (!data_rstn) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            idx_q   <= '0;
            tdata_q <= '0;
            tlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            idx_q   <= idx_d;
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
        end
    end

`ifdef AXI_DPD_CAPTURE_READER_RRESP_CHECK_EN
    logic rd_err_q, rd_err_d;

    always_ff @(posedge s_axi_aclk or negedge data_rstn) begin
        if (!data_rstn) begin
            rd_err_q <= 1'b0;
        end else begin
            rd_err_q <= rd_err_d;
        end
    end

    assign rd_err = rd_err_q;
`else
    logic unused_rresp;

    assign unused_rresp = ^m_axi_rresp;
    assign rd_err       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tdata_d = tdata_q;
        tlast_d = tlast_q;
`ifdef AXI_DPD_CAPTURE_READER_RRESP_CHECK_EN
        rd_err_d = rd_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    idx_d   = '0;
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                if (m_axi_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (m_axi_rvalid) begin
`ifdef AXI_DPD_CAPTURE_READER_RRESP_CHECK_EN
                    // A failed read drops the word and abandons the rest of the buffer.
                    if (m_axi_rresp != AXI_RESP_OKAY) begin
                        rd_err_d = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        tdata_d = m_axi_rdata;
                        tlast_d = (idx_q == {CAP_DEPTH{1'b1}});
                        state_d = ST_OUT;
                    end
`else
                    tdata_d = m_axi_rdata;
                    tlast_d = (idx_q == {CAP_DEPTH{1'b1}});
                    state_d = ST_OUT;
`endif
                end
            end
            ST_OUT: begin
                if (m_axis_tready) begin
                    if (tlast_q) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_AR;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Address is driven only while it is valid so the bus reads zero in reset and idle.
    assign m_axi_araddr  = (state_q == ST_AR)
                         ? ADDR_WIDTH'(word_addr(32'(BASE_ADDR), 32'(idx_q)))
                         : '0;
    assign m_axi_arvalid = (state_q == ST_AR);
    assign m_axi_arprot  = AXI_PROT_DEFAULT;
    assign m_axi_rready  = (state_q == ST_R);
    assign m_axis_tvalid = (state_q == ST_OUT);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = (state_q == ST_OUT) & tlast_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_axi_dpd_capture_reader.sv
// Bench for axi_dpd_capture_reader: AXI slave model with optional random delays,
// stream sink with throttling, and a scoreboard of expected beats.
module tb_axi_dpd_capture_reader;

    localparam int          CAP    = 4;
    localparam int          NW     = 16;
    localparam logic [15:0] BASE_B = 16'h1000;
`ifdef AXI_DPD_CAPTURE_READER_RRESP_CHECK_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic        s_axi_aclk;
    logic        data_rstn;
    logic        start;
    logic        busy, done, rd_err;
    logic        m_axi_arvalid;
    logic [15:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arready;
    logic        m_axi_rvalid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    logic        b_busy, b_done, b_rd_err, b_arvalid, b_rready, b_tvalid, b_tlast;
    logic [15:0] b_araddr;
    logic [2:0]  b_arprot;
    logic [31:0] b_tdata;

    axi_dpd_capture_reader #(.CAP_DEPTH(CAP), .ADDR_WIDTH(16), .BASE_ADDR(16'h0000)) dut (
        .s_axi_aclk(s_axi_aclk), .data_rstn(data_rstn), .start(start),
        .busy(busy), .done(done), .rd_err(rd_err),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arready(m_axi_arready), .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rready(m_axi_rready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    // Same stimulus, different base address; runs in lockstep with dut.
    axi_dpd_capture_reader #(.CAP_DEPTH(CAP), .ADDR_WIDTH(16), .BASE_ADDR(BASE_B)) dut_b (
        .s_axi_aclk(s_axi_aclk), .data_rstn(data_rstn), .start(start),
        .busy(b_busy), .done(b_done), .rd_err(b_rd_err),
        .m_axi_arvalid(b_arvalid), .m_axi_araddr(b_araddr), .m_axi_arprot(b_arprot),
        .m_axi_arready(m_axi_arready), .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rready(b_rready),
        .m_axis_tvalid(b_tvalid), .m_axis_tdata(b_tdata), .m_axis_tlast(b_tlast),
        .m_axis_tready(m_axis_tready)
    );

    initial s_axi_aclk = 1'b0;
    always #5 s_axi_aclk = ~s_axi_aclk;

    int cyc = 0;
    always @(posedge s_axi_aclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;
    exp_t sb_q[$];

    int ar_cnt;
    int beat_cnt;
    bit ar_rand;
    int sink_mode;
    int err_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // AXI slave model: word n holds 32'h1111_1111+n
    initial begin : slave
        int          sl_st;
        int          dly;
        int          rd_idx;
        logic        arv_s, rrd_s;
        logic [15:0] adr_s, adrb_s;
        exp_t        e;
        sl_st = 0; dly = 0; rd_idx = 0;
        arv_s = 1'b0; rrd_s = 1'b0; adr_s = '0; adrb_s = '0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        forever begin
            @(negedge s_axi_aclk);
            if (!data_rstn) begin
                sl_st = 0; dly = 0; arv_s = 1'b0; rrd_s = 1'b0;
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
                continue;
            end
            if (arv_s && !m_axi_arready) begin
                check("arvalid_hold", {31'd0, m_axi_arvalid}, 32'd1);
                check("araddr_stable", {16'd0, m_axi_araddr}, {16'd0, adr_s});
            end
            if (arv_s && m_axi_arready) begin
                check($sformatf("araddr_w%0d", ar_cnt), {16'd0, adr_s}, 32'(4 * ar_cnt));
                check($sformatf("araddr_b_w%0d", ar_cnt), {16'd0, adrb_s}, 32'(BASE_B) + 32'(4 * ar_cnt));
                rd_idx = int'(adr_s >> 2);
                ar_cnt++;
                m_axi_arready = 1'b0;
                sl_st = 1;
                dly = ar_rand ? int'($urandom_range(0, 5)) : 0;
            end
            if (rrd_s && m_axi_rvalid) begin
                m_axi_rvalid = 1'b0;
                sl_st = 0;
                dly = ar_rand ? int'($urandom_range(0, 5)) : 0;
            end
            if (sl_st == 0) begin
                if (m_axi_arvalid && !m_axi_arready) begin
                    if (dly == 0) m_axi_arready = 1'b1;
                    else dly--;
                end
            end else if (!m_axi_rvalid) begin
                if (dly == 0) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = 32'h1111_1111 + 32'(rd_idx);
                    m_axi_rresp  = (rd_idx == err_word) ? 2'b10 : 2'b00;
                    if (!(FEAT && rd_idx == err_word)) begin
                        e.data = m_axi_rdata;
                        e.last = (rd_idx == NW - 1);
                        sb_q.push_back(e);
                    end
                end else begin
                    dly--;
                end
            end
            arv_s  = m_axi_arvalid;
            rrd_s  = m_axi_rready;
            adr_s  = m_axi_araddr;
            adrb_s = b_araddr;
        end
    end

    // Stream sink + scoreboard compare
    initial begin : sink
        logic        tv_s, tr_s;
        logic [31:0] td_s;
        exp_t        e;
        tv_s = 1'b0; tr_s = 1'b0; td_s = '0;
        m_axis_tready = 1'b0;
        forever begin
            @(negedge s_axi_aclk);
            if (!data_rstn) begin
                tv_s = 1'b0;
                continue;
            end
            if (tv_s && !tr_s) begin
                check("tvalid_hold", {31'd0, m_axis_tvalid}, 32'd1);
                check("tdata_stable", m_axis_tdata, td_s);
            end
            case (sink_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b0;
            endcase
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected no beat", m_axis_tdata);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("tdata_b%0d", beat_cnt), m_axis_tdata, e.data);
                    check($sformatf("tlast_b%0d", beat_cnt), {31'd0, m_axis_tlast}, {31'd0, e.last});
                end
                beat_cnt++;
            end
            tv_s = m_axis_tvalid;
            tr_s = m_axis_tready;
            td_s = m_axis_tdata;
        end
    end

    task automatic wait_done(output bit ok, output int dcyc, output bit busy_bad);
        ok = 1'b0; dcyc = 0; busy_bad = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                ok = 1'b1;
                dcyc = cyc;
                break;
            end
            if (!busy) busy_bad = 1'b1;
            @(negedge s_axi_aclk);
        end
    endtask

    task automatic wait_beats(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (beat_cnt >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge s_axi_aclk);
        end
    endtask

    task automatic pulse_start(output int s_cyc);
        @(negedge s_axi_aclk);
        start = 1'b1;
        s_cyc = cyc;
        @(negedge s_axi_aclk);
        start = 1'b0;
        @(negedge s_axi_aclk);
    endtask

    task automatic run_xfer(input string tag, input bit ideal, input int exp_beats,
                            input int exp_ars, input logic exp_err);
        int s_cyc, d_cyc;
        bit ok, busy_bad;
        ar_cnt = 0;
        beat_cnt = 0;
        ar_rand = !ideal;
        sink_mode = ideal ? 0 : 1;
        pulse_start(s_cyc);
        wait_done(ok, d_cyc, busy_bad);
        check({tag, "_done_seen"}, {31'd0, ok}, 32'd1);
        check({tag, "_busy_during"}, {31'd0, busy_bad}, 32'd0);
        if (ideal && exp_beats == NW) check({tag, "_latency"}, d_cyc - s_cyc + 1, 3 * NW + 2);
        @(negedge s_axi_aclk);
        check({tag, "_busy_after"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_beats"}, beat_cnt, exp_beats);
        check({tag, "_ar_count"}, ar_cnt, exp_ars);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
        check({tag, "_rd_err"}, {31'd0, rd_err}, {31'd0, exp_err});
        repeat (3) @(negedge s_axi_aclk);
    endtask

    typedef struct {
        string tag;
        bit    ideal;
        int    err_word;
        int    exp_beats;
        int    exp_ars;
        logic  exp_err;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int  s_cyc, d_cyc;
        bit  ok, busy_bad, restarted;

        vecs[0] = '{"ideal",     1'b1, -1, NW, NW, 1'b0};
        vecs[1] = '{"random",    1'b0, -1, NW, NW, 1'b0};
        vecs[2] = '{"rresp_err", 1'b1,  3, FEAT ? 3 : NW, FEAT ? 4 : NW, FEAT};
        vecs[3] = '{"sticky",    1'b0, -1, NW, NW, FEAT};

        start = 1'b0; data_rstn = 1'b0; sink_mode = 0; ar_rand = 1'b0;
        err_word = -1; ar_cnt = 0; beat_cnt = 0;
        #1;
        check("rst_ctrl", {25'd0, busy, done, rd_err, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast}, 32'd0);
        check("rst_araddr", {16'd0, m_axi_araddr}, 32'd0);
        check("rst_araddr_b", {16'd0, b_araddr}, 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("arprot", {29'd0, m_axi_arprot}, 32'd0);
        repeat (3) @(negedge s_axi_aclk);
        data_rstn = 1'b1;
        repeat (2) @(negedge s_axi_aclk);

        for (int v = 0; v < 4; v++) begin
            err_word = vecs[v].err_word;
            run_xfer(vecs[v].tag, vecs[v].ideal, vecs[v].exp_beats, vecs[v].exp_ars, vecs[v].exp_err);
        end
        err_word = -1;

        // Start edges while busy and during the done cycle are ignored.
        ar_cnt = 0; beat_cnt = 0; ar_rand = 1'b0; sink_mode = 0;
        pulse_start(s_cyc);
        wait_beats(5, ok);
        check("ign_reach5", {31'd0, ok}, 32'd1);
        start = 1'b1;
        wait_beats(10, ok);
        check("ign_reach10", {31'd0, ok}, 32'd1);
        start = 1'b0;
        wait_done(ok, d_cyc, busy_bad);
        check("ign_done", {31'd0, ok}, 32'd1);
        start = 1'b1;
        restarted = 1'b0;
        repeat (20) begin
            @(negedge s_axi_aclk);
            if (busy) restarted = 1'b1;
        end
        check("ign_no_restart", {31'd0, restarted}, 32'd0);
        check("ign_ar_count", ar_cnt, NW);
        check("ign_beats", beat_cnt, NW);
        start = 1'b0;
        @(negedge s_axi_aclk);
        run_xfer("after_ign", 1'b1, NW, NW, FEAT);

        // Asynchronous reset while a beat is stalled.
        ar_cnt = 0; beat_cnt = 0; ar_rand = 1'b0; sink_mode = 0;
        pulse_start(s_cyc);
        wait_beats(7, ok);
        check("rst_reach7", {31'd0, ok}, 32'd1);
        sink_mode = 2;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_axis_tvalid) begin
                ok = 1'b1;
                break;
            end
            @(negedge s_axi_aclk);
        end
        check("rst_stalled", {31'd0, ok}, 32'd1);
        repeat (2) @(negedge s_axi_aclk);
        #2;
        data_rstn = 1'b0;
        #1;
        check("arst_ctrl", {25'd0, busy, done, rd_err, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast}, 32'd0);
        check("arst_araddr", {16'd0, m_axi_araddr}, 32'd0);
        check("arst_tdata", m_axis_tdata, 32'd0);
        sb_q.delete();
        sink_mode = 0;
        repeat (3) @(negedge s_axi_aclk);
        data_rstn = 1'b1;
        repeat (2) @(negedge s_axi_aclk);
        run_xfer("post_reset", 1'b1, NW, NW, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
